// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load.
// Registered serial output plus a per-frame shift counter with a done pulse.
module universal_shift_register #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [1:0]       Mode_In,
  input  logic             Serial_Data_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  output logic             Serial_Data_Out,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic [CNT_W-1:0] Shift_Count,
  output logic             Frame_Done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam int         LAST      = WIDTH - 1;

  logic [WIDTH-1:0] r_data;
  logic             r_sout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_shift;
  logic             w_wrap;

  assign w_shift = Enable_In &&
                   (Mode_In == MODE_SHR || Mode_In == MODE_SHL);
  assign w_wrap  = (r_cnt == CNT_W'(LAST));

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_data <= '0;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Enable_In) begin
        unique case (Mode_In)
          MODE_SHR: begin
            r_data <= {Serial_Data_In, r_data[WIDTH-1:1]};
            r_sout <= r_data[0];
          end
          MODE_SHL: begin
            r_data <= {r_data[WIDTH-2:0], Serial_Data_In};
            r_sout <= r_data[WIDTH-1];
          end
          MODE_LOAD: begin
            r_data <= Parallel_Data_In;
            r_cnt  <= '0;
          end
          MODE_HOLD: ;
        endcase
      end
      // Both shift directions advance the same frame counter.
      if (w_shift) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign Parallel_Data_Out = r_data;
  assign Serial_Data_Out   = r_sout;
  assign Shift_Count       = r_cnt;
  assign Frame_Done        = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH 8 and 16).
// Vector table plus hand-written multi-cycle sequences.
module tb_universal_shift_register;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] pin;
    logic [7:0] pout;
    logic       sout;
    logic [2:0] cnt;
    logic       done;
  } vec_t;

  typedef struct {
    string      nm;
    logic [7:0] pout;
    logic       sout;
    logic [2:0] cnt;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        sin = 1'b0;
  logic [7:0]  pin = 8'h00;
  logic        sout8, done8;
  logic [7:0]  pout8;
  logic [2:0]  cnt8;
  logic        sout16, done16;
  logic [15:0] pout16;
  logic [3:0]  cnt16;

  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t tv[23];

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Mode_In           (mode),
    .Serial_Data_In    (sin),
    .Parallel_Data_In  (pin),
    .Serial_Data_Out   (sout8),
    .Parallel_Data_Out (pout8),
    .Shift_Count       (cnt8),
    .Frame_Done        (done8)
  );

  universal_shift_register #(.WIDTH(16)) u_dut16 (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Mode_In           (mode),
    .Serial_Data_In    (sin),
    .Parallel_Data_In  ({pin, pin}),
    .Serial_Data_Out   (sout16),
    .Parallel_Data_Out (pout16),
    .Shift_Count       (cnt16),
    .Frame_Done        (done16)
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic e,
                      input logic [1:0] m, input logic s,
                      input logic [7:0] p, input logic [7:0] ep,
                      input logic es, input logic [2:0] ec,
                      input logic ed);
    exp_t x;
    rst = r; en = e; mode = m; sin = s; pin = p;
    x.nm = nm; x.pout = ep; x.sout = es; x.cnt = ec; x.done = ed;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      x = sb.pop_front();
      chk({x.nm, ".pout"}, {8'h00, pout8}, {8'h00, x.pout});
      chk({x.nm, ".sout"}, {15'h0, sout8}, {15'h0, x.sout});
      chk({x.nm, ".cnt"},  {13'h0, cnt8},  {13'h0, x.cnt});
      chk({x.nm, ".done"}, {15'h0, done8}, {15'h0, x.done});
    end
  endtask

  initial begin
    logic [7:0] ep;
    tv[0]  = '{1'b1, 1'b1, 2'b11, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 8'h5A, 8'h00, 1'b0, 3'd0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 8'hA5, 8'hA5, 1'b0, 3'd0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h52, 1'b1, 3'd1, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h29, 1'b0, 3'd2, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h14, 1'b1, 3'd3, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h0A, 1'b0, 3'd4, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h05, 1'b0, 3'd5, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h02, 1'b1, 3'd6, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h01, 1'b0, 3'd7, 1'b0};
    tv[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1};
    tv[11] = '{1'b1, 1'b1, 2'b10, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0};
    tv[12] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h00, 8'h01, 1'b0, 3'd1, 1'b0};
    tv[13] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h00, 8'h03, 1'b0, 3'd2, 1'b0};
    tv[14] = '{1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h06, 1'b0, 3'd3, 1'b0};
    tv[15] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h00, 8'h0D, 1'b0, 3'd4, 1'b0};
    tv[16] = '{1'b0, 1'b0, 2'b11, 1'b1, 8'hFF, 8'h0D, 1'b0, 3'd4, 1'b0};
    tv[17] = '{1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 8'h0D, 1'b0, 3'd4, 1'b0};
    tv[18] = '{1'b0, 1'b1, 2'b01, 1'b1, 8'h00, 8'h86, 1'b1, 3'd5, 1'b0};
    tv[19] = '{1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h0C, 1'b1, 3'd6, 1'b0};
    tv[20] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h00, 8'h19, 1'b0, 3'd7, 1'b0};
    tv[21] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 8'h0C, 1'b1, 3'd0, 1'b1};
    tv[22] = '{1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 8'h0C, 1'b1, 3'd0, 1'b0};

    foreach (tv[i])
      step($sformatf("vec%0d", i), tv[i].rst, tv[i].en, tv[i].mode,
           tv[i].sin, tv[i].pin, tv[i].pout, tv[i].sout, tv[i].cnt,
           tv[i].done);

    // Hold and enable: 5 shifts, 3 disabled cycles, 3 more shifts.
    step("hold.rst", 1'b1, 1'b1, 2'b01, 1'b1, 8'h00,
         8'h00, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      ep = ~(8'hFF >> k);
      step($sformatf("hold.sh%0d", k), 1'b0, 1'b1, 2'b01, 1'b1, 8'h00,
           ep, 1'b0, 3'(k), 1'b0);
    end
    for (int k = 0; k < 3; k++)
      step($sformatf("hold.off%0d", k), 1'b0, 1'b0, 2'b01, 1'b0, 8'h00,
           8'hF8, 1'b0, 3'd5, 1'b0);
    for (int k = 6; k <= 8; k++) begin
      ep = ~(8'hFF >> k);
      step($sformatf("hold.sh%0d", k), 1'b0, 1'b1, 2'b01, 1'b1, 8'h00,
           ep, 1'b0, 3'(k % 8), 1'(k == 8));
    end

    // Reset after 5 shifts aborts the frame without a pulse.
    for (int k = 1; k <= 5; k++) begin
      ep = 8'hFF >> k;
      step($sformatf("abrt.sh%0d", k), 1'b0, 1'b1, 2'b01, 1'b0, 8'h00,
           ep, 1'b1, 3'(k), 1'b0);
    end
    step("abrt.rst", 1'b1, 1'b1, 2'b01, 1'b0, 8'h00,
         8'h00, 1'b0, 3'd0, 1'b0);
    step("abrt.sh", 1'b0, 1'b1, 2'b01, 1'b0, 8'h00,
         8'h00, 1'b0, 3'd1, 1'b0);

    // Load at Shift_Count = 7 wins over the frame-completing shift.
    step("ld.ff", 1'b0, 1'b1, 2'b11, 1'b0, 8'hFF,
         8'hFF, 1'b0, 3'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      ep = 8'hFF << k;
      step($sformatf("ld.sh%0d", k), 1'b0, 1'b1, 2'b10, 1'b0, 8'h00,
           ep, 1'b1, 3'(k), 1'b0);
    end
    step("ld.3c", 1'b0, 1'b1, 2'b11, 1'b0, 8'h3C,
         8'h3C, 1'b1, 3'd0, 1'b0);
    step("ld.sh", 1'b0, 1'b1, 2'b10, 1'b0, 8'h00,
         8'h78, 1'b0, 3'd1, 1'b0);

    // SISO latency on both widths, with back-to-back frames.
    step("siso.rst", 1'b1, 1'b1, 2'b01, 1'b0, 8'h00,
         8'h00, 1'b0, 3'd0, 1'b0);
    chk("siso16.rst.pout", pout16, 16'h0000);
    chk("siso16.rst.cnt", {12'h0, cnt16}, 16'h0000);
    for (int k = 1; k <= 17; k++) begin
      ep = (k <= 8) ? (8'h80 >> (k - 1)) : 8'h00;
      step($sformatf("siso.sh%0d", k), 1'b0, 1'b1, 2'b01, 1'(k == 1),
           8'h00, ep, 1'(k == 9), 3'(k % 8), 1'(k == 8 || k == 16));
      chk($sformatf("siso16.sout%0d", k), {15'h0, sout16},
          {15'h0, 1'(k == 17)});
      chk($sformatf("siso16.done%0d", k), {15'h0, done16},
          {15'h0, 1'(k == 16)});
      chk($sformatf("siso16.cnt%0d", k), {12'h0, cnt16},
          {12'h0, 4'(k % 16)});
    end

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
